strength_arbiter: RTL
=====================

# strength_arbiter

Shared-line drive scheduler for the signal-strength test area. It arbitrates N requesters that each want to drive one shared net with a value at a given drive strength. It grants one owner at a time, with the stronger requester winning. It presents the resolved value, enable and strength as registered outputs, and flags equal-strength value conflicts.

## Interface
- `N_REQ`, 4: number of requesters (2..8)
- `STR_W`, 3: strength code width; 0 = highz, 1 = weak, 2 = pull, 3 = strong, 7 = supply, ordered numerically
- `HOLD_MAX`, 15: maximum consecutive owned cycles before a forced release (≥1)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req`  in  N_REQ  per-requester drive request, level
- `rel`  in  N_REQ  per-requester release pulse, only meaningful from the current owner
- `val`  in  N_REQ  per-requester drive value
- `str`  in  N_REQ*STR_W  per-requester strength; slice i is `[i*STR_W +: STR_W]`
- `gnt`  out  N_REQ  one-hot current owner, or all zero
- `line_o`  out  1  resolved line value
- `line_oe`  out  1  line driven (0 = highz)
- `line_str`  out  STR_W  strength of the current driver
- `conflict`  out  1  an equal-strength requester wants the opposite value
- `busy`  out  1  a grant is active

## Operation
- A request is eligible when its `req` = 1 and its `str` ≠ 0. Strength-0 requests are never granted.
- The FSM has two states:
  - IDLE: no owner.
  - OWN: exactly one `gnt` bit is set.
- IDLE → OWN: when any request is eligible, select the highest `str`. Break ties round-robin, starting at pointer `rr_ptr`.
  - `rr_ptr` becomes winner+1 modulo N_REQ.
  - The hold counter loads 1.
- OWN → IDLE:
  - on owner `rel` = 1, or
  - on owner `req` = 0, or
  - on owner `str` changing to 0, or
  - when the hold counter reaches HOLD_MAX (timeout).
  - On timeout, the previous owner is masked from the next arbitration only.
- OWN → OWN (preemption, only when `STRENGTH_ARB_PREEMPT_EN` is set): another eligible requester has `str` strictly greater than the owner's current `str`. The grant transfers to the strongest such requester, ties broken round-robin. The counter reloads 1 and `rr_ptr` updates.
- Equal strength never preempts.
- While in OWN:
  - `line_o` = owner `val`, `line_oe` = 1, `line_str` = owner `str`, all tracking the owner's live inputs registered one cycle.
  - `conflict` = 1 when any non-owner eligible requester has `str` equal to the owner's and `val` different from it.
- In IDLE: `line_oe` = 0, `line_o` = 0, `line_str` = 0, `conflict` = 0.
- The hold counter is STR-independent, `$clog2(HOLD_MAX+1)` bits wide, and saturates; it does not wrap.

## Timing
- Reset values (asynchronous): `gnt` = 0, `line_o` = 0, `line_oe` = 0, `line_str` = 0, `conflict` = 0, `busy` = 0, `rr_ptr` = 0, counter = 0, state IDLE.
- All outputs are registered.
- Request sampled at edge t → `gnt`/`busy`/`line_*` valid after edge t+1.
- Release sampled at edge t → `gnt` = 0 after edge t+1. At least one IDLE cycle always follows a release or timeout; re-arbitration happens at the next edge.
- A release and a preemption in the same cycle count as preemption: the preemptor is granted directly, with no IDLE cycle.
- Timeout coinciding with a stronger request: preemption takes priority.
- `rel` from a non-owner is ignored.
- `rel` held high across a regrant: a requester's `rel` is honoured only in cycles where it owns the line.
- Reset asserted mid-grant: outputs clear immediately, with no clock needed. Arbitration resumes at the first edge after deassertion with `rr_ptr` = 0.

## Configuration
- `STRENGTH_ARB_PREEMPT_EN` defined: strictly stronger requests preempt the owner, as described above.
- Not defined:
  - Arbitration is non-preemptive. The owner keeps the line until release, drop or timeout, regardless of stronger requests.
  - Strength still orders selection in IDLE.
  - `conflict` still reports equal-strength opposite-value requesters.

## Test plan
- Single requester: after reset, req0 = 1, str0 = 1 (weak), val0 = 0 → after 1 edge, `gnt` = 0001, `line_oe` = 1, `line_o` = 0, `line_str` = 1.
- Preempt (macro on): owner req0 weak, value 0; then req2 with str2 = 3, val2 = 1 → next edge `gnt` = 0100, `line_o` = 1, `line_str` = 3. With the macro off, `gnt` stays 0001.
- Round-robin tie: req0..3 all asserted at str = 2, each releasing after 2 cycles → grants 0001, 0010, 0100, 1000, 0001, each separated by one IDLE cycle.
- Timeout: HOLD_MAX = 4, req1 held with no rel → `gnt` = 0010 for 4 cycles, one IDLE cycle, then req0 (if requesting) is granted before req1 is regranted.
- Conflict and highz: owner req0 str = 3 val = 1, req1 str = 3 val = 0 → `conflict` = 1 next edge. A req3 with str = 0 is never granted, even when it is the only requester.
- Async reset mid-grant: assert `rst` between edges while `gnt` = 0100 → all outputs 0 before the next edge. After deassertion, simultaneous equal-strength req0/req2 → req0 is granted.

Source files
------------

// File: rtl/strength_arbiter.sv
// Shared-net drive scheduler: grants one requester at a time, strongest first, round-robin on ties.
// Optional preemption by strictly stronger requesters is enabled with `define STRENGTH_ARB_PREEMPT_EN.
module strength_arbiter #(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned STR_W    = 3,
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       rel,
    input  logic [N_REQ-1:0]       val,
    input  logic [N_REQ*STR_W-1:0] str,
    output logic [N_REQ-1:0]       gnt,
    output logic                   line_o,
    output logic                   line_oe,
    output logic [STR_W-1:0]       line_str,
    output logic                   conflict,
    output logic                   busy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(HOLD_MAX + 1);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   mask_q, mask_d;

    logic [N_REQ-1:0]   gnt_d;
    logic               line_o_d, line_oe_d, conflict_d, busy_d;
    logic [STR_W-1:0]   line_str_d;

    logic [N_REQ-1:0]   eligible;
    logic [N_REQ-1:0]   stronger;
    logic [STR_W-1:0]   owner_str;
    logic               idle_found, pre_found, owner_gone;
    logic [IDX_W-1:0]   idle_win, pre_win;

    // Strongest candidate; ties resolved by first hit scanning upward from ptr.
    function automatic logic [IDX_W:0] pick(input logic [N_REQ-1:0]       cand,
                                            input logic [N_REQ*STR_W-1:0] strs,
                                            input logic [IDX_W-1:0]       ptr);
        logic [STR_W-1:0] best;
        logic             found;
        logic [IDX_W-1:0] win;
        int unsigned      j;
        best  = '0;
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (cand[i] && (strs[i*STR_W +: STR_W] > best)) begin
                best = strs[i*STR_W +: STR_W];
            end
        end
        for (int k = 0; k < N_REQ; k++) begin
            j = (32'(ptr) + 32'(k)) % N_REQ;
            if (!found && cand[j] && (strs[j*STR_W +: STR_W] == best)) begin
                found = 1'b1;
                win   = IDX_W'(j);
            end
        end
        return {found, win};
    endfunction

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] w);
        return (32'(w) == N_REQ - 1) ? '0 : w + IDX_W'(1);
    endfunction

    // Next-state, arbitration and registered-output values.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        gnt_d      = '0;
        line_o_d   = 1'b0;
        line_oe_d  = 1'b0;
        line_str_d = '0;
        conflict_d = 1'b0;
        busy_d     = 1'b0;

        for (int i = 0; i < N_REQ; i++) begin
            eligible[i] = req[i] && (str[i*STR_W +: STR_W] != '0);
        end
        owner_str  = str[owner_q*STR_W +: STR_W];
        owner_gone = rel[owner_q] || !eligible[owner_q];

`ifdef STRENGTH_ARB_PREEMPT_EN
        for (int i = 0; i < N_REQ; i++) begin
            stronger[i] = eligible[i] && (IDX_W'(i) != owner_q)
                          && (str[i*STR_W +: STR_W] > owner_str);
        end
`else
        stronger = '0;
`endif

        {idle_found, idle_win} = pick(eligible & ~mask_q, str, rr_q);
        {pre_found, pre_win}   = pick(stronger, str, rr_q);

        case (state_q)
            IDLE: begin
                mask_d = '0;
                if (idle_found) begin
                    state_d = OWN;
                    owner_d = idle_win;
                    rr_d    = rr_next(idle_win);
                    cnt_d   = CNT_W'(1);
                end
            end
            OWN: begin
                if (pre_found) begin
                    owner_d = pre_win;
                    rr_d    = rr_next(pre_win);
                    cnt_d   = CNT_W'(1);
                end else if (owner_gone) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_W'(HOLD_MAX)) begin
                    state_d         = IDLE;
                    cnt_d           = '0;
                    mask_d          = '0;
                    mask_d[owner_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == OWN) begin
            gnt_d[owner_d] = 1'b1;
            busy_d         = 1'b1;
            line_oe_d      = 1'b1;
            line_o_d       = val[owner_d];
            line_str_d     = str[owner_d*STR_W +: STR_W];
            for (int i = 0; i < N_REQ; i++) begin
                if ((IDX_W'(i) != owner_d) && eligible[i]
                    && (str[i*STR_W +: STR_W] == line_str_d) && (val[i] != val[owner_d])) begin
                    conflict_d = 1'b1;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_q     <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
            gnt      <= '0;
            line_o   <= 1'b0;
            line_oe  <= 1'b0;
            line_str <= '0;
            conflict <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            gnt      <= gnt_d;
            line_o   <= line_o_d;
            line_oe  <= line_oe_d;
            line_str <= line_str_d;
            conflict <= conflict_d;
            busy     <= busy_d;
        end
    end

endmodule
